// File: rtl/logicfunction_pkg.sv
// Purpose : shared types and sizes for the logic-function sweep checker.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package logicfunction_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 16;  // all input combinations of a,b,c,d
  localparam int VEC_W       = 4;   // width of the vector index
  localparam int ERR_W       = 5;   // holds 0..16 mismatches without wrap

endpackage

// File: rtl/sweep_hold_timer.sv
// Purpose : counts cycles a vector has been held and strobes the sample cycle.
// Latency : sample asserts in the HOLD_CYCLES-th enabled cycle after a clear.
// Backpressure: none; counts whenever en is high, clear has priority.
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   clear        - restart the count from zero on the next cycle
//   en           - count this cycle (high while vectors are being driven)
//   sample       - high in the last hold cycle of the current vector
module sweep_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic sample
);

  // A single-cycle hold still needs a 1-bit counter; it simply stays at 0.
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign sample = en && (hold_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/logicfunction_sweep_checker.sv
// Purpose : drives all 16 vectors into a 4-input function and checks f against a truth table.
// Latency : vector k on a..d in cycles 1+k*H..(k+1)*H after start; done in cycle 16*H+1.
// Backpressure: none; start is honoured only in IDLE and is dropped otherwise.
//
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   start, exp_tt     - sweep request and expected truth table (latched on accepted start)
//   f                 - response of the function under test
//   a, b, c, d        - registered drive to the function (a is the vector MSB)
//   busy, done        - sweep in progress / one-cycle completion pulse
//   pass, err_count, fail_mask - sweep result, held until the next accepted start
module logicfunction_sweep_checker
  import logicfunction_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_VECTORS-1:0] exp_tt,
  input  logic                   f,
  output logic                   a,
  output logic                   b,
  output logic                   c,
  output logic                   d,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count,
  output logic [NUM_VECTORS-1:0] fail_mask
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_t                 state;
  logic [VEC_W-1:0]       vec;
  logic [NUM_VECTORS-1:0] exp_q;
  logic                   sample;
  logic                   mismatch;
  logic [ERR_W-1:0]       err_next;

  // Counter restarts on every sample (vector advance or final sample) and
  // is held at zero while idle so the first vector gets a full hold.
  sweep_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state == IDLE) || sample),
    .en     (state == DRIVE),
    .sample (sample)
  );

  assign mismatch = (f != exp_q[vec]);

  // Count including the current sample, so pass reflects the final vector.
  assign err_next = err_count + {{(ERR_W-1){1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      vec          <= '0;
      exp_q        <= '0;
      {a, b, c, d} <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_mask    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= DRIVE;
            vec          <= '0;
            exp_q        <= exp_tt;
            {a, b, c, d} <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_mask    <= '0;
          end
        end
        DRIVE: begin
          if (sample) begin
            err_count <= err_next;
            if (mismatch) begin
              fail_mask[vec] <= 1'b1;
            end
            if (vec == LAST_VEC) begin
              // Results and done appear together in the DONE cycle.
              state        <= DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              pass         <= (err_next == '0);
              {a, b, c, d} <= '0;
            end else begin
              vec          <= vec + 1'b1;
              {a, b, c, d} <= vec + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logicfunction_sweep_checker.sv
// Purpose : randomized scoreboard bench for the sweep checker, H=4 and H=1 instances.
// Latency : expected results queued at start, popped when done is seen.
// Backpressure: n/a.
module tb_logicfunction_sweep_checker;

  localparam int H0 = 4;
  localparam int H1 = 1;

  typedef struct packed {
    logic        pass;
    logic [4:0]  err;
    logic [15:0] mask;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance 0 (H=4)
  logic rst0, start0, f0, a0, b0, c0, d0, busy0, done0, pass0;
  logic [15:0] exp0, mask0;
  logic [4:0]  err0;
  // instance 1 (H=1)
  logic rst1, start1, f1, a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] exp1, mask1;
  logic [4:0]  err1;

  // Truth table actually implemented by the emulated function under test.
  logic [15:0] ttf [2];
  int          act [2];      // start cycle of the running sweep, -1 if none
  int          hold [2];
  logic        mon_en [2];
  res_t        q0 [$];
  res_t        q1 [$];

  assign f0 = ttf[0][{a0, b0, c0, d0}];
  assign f1 = ttf[1][{a1, b1, c1, d1}];

  logicfunction_sweep_checker #(.HOLD_CYCLES(H0)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .exp_tt(exp0), .f(f0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_mask(mask0)
  );

  logicfunction_sweep_checker #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .exp_tt(exp1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_mask(mask1)
  );

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d got %0h want %0h", name, i, cyc, got, want);
    end
  endtask

  // Per-cycle expectations from the start cycle alone, plus scoreboard pop on done.
  task automatic mon(input int i, input logic bsy, input logic dn, input logic ps,
                     input logic [3:0] v, input logic [4:0] er, input logic [15:0] mk);
    int   k;
    int   h;
    logic e_busy;
    logic e_done;
    logic [3:0] e_v;
    res_t r;
    h = hold[i];
    e_busy = 1'b0;
    e_done = 1'b0;
    e_v = 4'd0;
    k = -1;
    if (act[i] >= 0) begin
      k = cyc - act[i];
      if (k >= 1 && k <= 16 * h) begin
        e_busy = 1'b1;
        e_v = 4'((k - 1) / h);
      end else if (k == 16 * h + 1) begin
        e_done = 1'b1;
      end
    end
    chk("busy", i, 32'(bsy), 32'(e_busy));
    chk("done", i, 32'(dn), 32'(e_done));
    chk("vector", i, 32'(v), 32'(e_v));
    if (e_busy) chk("pass_during_sweep", i, 32'(ps), 32'd0);
    if (dn) begin
      if (i == 0 && q0.size() > 0) begin
        r = q0.pop_front();
      end else if (i == 1 && q1.size() > 0) begin
        r = q1.pop_front();
      end else begin
        r = '0;
        chk("unexpected_done", i, 32'd1, 32'd0);
      end
      chk("pass", i, 32'(ps), 32'(r.pass));
      chk("err_count", i, 32'(er), 32'(r.err));
      chk("fail_mask", i, 32'(mk), 32'(r.mask));
    end
    if (act[i] >= 0 && k >= 16 * h + 1) act[i] = -1;
  endtask

  always @(negedge clk) begin
    if (mon_en[0]) mon(0, busy0, done0, pass0, {a0, b0, c0, d0}, err0, mask0);
    if (mon_en[1]) mon(1, busy1, done1, pass1, {a1, b1, c1, d1}, err1, mask1);
  end

  task automatic at_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one cycle; queue an expected result only if the block is idle.
  task automatic go(input int i, input logic [15:0] e);
    logic rs;
    res_t r;
    int   t;
    t = cyc;
    rs = (i == 0) ? rst0 : rst1;
    if (i == 0) begin start0 = 1'b1; exp0 = e; end
    else        begin start1 = 1'b1; exp1 = e; end
    if (!rs && act[i] < 0) begin
      act[i] = t;
      r.mask = ttf[i] ^ e;
      r.err  = 5'($countones(r.mask));
      r.pass = (r.mask == 16'h0);
      if (i == 0) q0.push_back(r); else q1.push_back(r);
    end
    at_cycle(t + 1);
    if (i == 0) start0 = 1'b0; else start1 = 1'b0;
  endtask

  task automatic sweep(input int i, input logic [15:0] tt, input logic [15:0] e);
    int s;
    s = cyc;
    ttf[i] = tt;
    go(i, e);
    at_cycle(s + 16 * hold[i] + 2);
  endtask

  task automatic chk_results_zero(input int i);
    if (i == 0) begin
      chk("rst_pass", 0, 32'(pass0), 32'd0);
      chk("rst_err", 0, 32'(err0), 32'd0);
      chk("rst_mask", 0, 32'(mask0), 32'd0);
    end else begin
      chk("rst_pass", 1, 32'(pass1), 32'd0);
      chk("rst_err", 1, 32'(err1), 32'd0);
      chk("rst_mask", 1, 32'(mask1), 32'd0);
    end
  endtask

  initial begin
    int s;
    logic [15:0] e;
    logic [15:0] t;
    hold[0] = H0;
    hold[1] = H1;
    act[0] = -1;
    act[1] = -1;
    mon_en[0] = 1'b0;
    mon_en[1] = 1'b0;
    ttf[0] = 16'h0;
    ttf[1] = 16'h0;
    // Reset held three cycles with start high on both instances.
    rst0 = 1'b1; rst1 = 1'b1;
    start0 = 1'b1; start1 = 1'b1;
    exp0 = 16'hFFFF; exp1 = 16'hFFFF;
    at_cycle(1);
    mon_en[0] = 1'b1;
    mon_en[1] = 1'b1;
    at_cycle(2);
    chk_results_zero(0);
    chk_results_zero(1);
    at_cycle(3);
    rst0 = 1'b0; rst1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    at_cycle(5);

    // Clean pass, partial fail, total fail.
    sweep(0, 16'hA5C3, 16'hA5C3);
    sweep(0, 16'h0000, 16'h8001);
    e = 16'($urandom);
    sweep(0, ~e, e);

    // Ignored re-starts and exp_tt changed mid-sweep.
    s = cyc;
    ttf[0] = 16'($urandom);
    e = 16'($urandom);
    go(0, e);
    at_cycle(s + 5);
    exp0 = ~e;
    at_cycle(s + 10);
    go(0, 16'($urandom));
    at_cycle(s + 65);
    go(0, 16'($urandom));
    at_cycle(s + 67);

    // Mid-sweep reset, then an H=1 sweep starting ten cycles later.
    s = cyc;
    ttf[0] = 16'h0F0F;
    go(0, 16'h00FF);
    at_cycle(s + 30);
    rst0 = 1'b1;
    at_cycle(s + 31);
    rst0 = 1'b0;
    act[0] = -1;
    q0.delete();
    chk_results_zero(0);
    at_cycle(s + 40);
    ttf[1] = 16'($urandom);
    go(1, 16'($urandom));
    at_cycle(s + 58);

    // Randomized sweeps on both instances, including single-bit faults.
    for (int n = 0; n < 6; n++) begin
      e = 16'($urandom);
      t = (n % 2 == 0) ? (e ^ (16'h1 << $urandom_range(15, 0))) : 16'($urandom);
      sweep(1, t, e);
      if (n < 3) sweep(0, t, e);
    end

    chk("pending_results0", 0, 32'(q0.size()), 32'd0);
    chk("pending_results1", 1, 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logicfunction_sweep_checker.md
# logicfunction_sweep_checker

Self-running exhaustive stimulus and response checker for a 4-input combinational logic function (inputs a, b, c, d; output f). It sits directly upstream and downstream of the logic-function block. It drives all 16 input vectors in ascending order, holds each for a programmable number of cycles, and samples f. It compares each sample against an expected 16-bit truth table and reports a pass/fail summary, so the function can be checked in hardware without a simulator bench.

## Interface
Parameters:
- HOLD_CYCLES, default 4: cycles each vector is driven before f is sampled; legal range ≥1.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- exp_tt  in  16  expected truth table; bit i is the expected f for vector i = {a,b,c,d}. Latched on accepted start.
- f  in  1  output of the function under test; combinational from a..d.
- a, b, c, d  out  1 each  drive to the function; a = vec[3] (MSB), d = vec[0].
- busy  out  1  high from the cycle after an accepted start through the last DRIVE cycle.
- done  out  1  single-cycle pulse when a sweep completes.
- pass  out  1  1 if err_count==0 at completion; valid from done, held until the next accepted start.
- err_count  out  5  number of mismatching vectors, 0..16.
- fail_mask  out  16  bit i set if vector i mismatched.

## Operation
- States:
  - IDLE: start=1 → DRIVE. On this transition: vec←0, hold_cnt←0, exp_q←exp_tt, err_count←0, fail_mask←0, pass←0.
  - DRIVE:
    - hold_cnt increments each cycle.
    - When hold_cnt==HOLD_CYCLES-1, sample f. On mismatch (f≠exp_q[vec]): err_count+1, fail_mask[vec]←1.
    - Then, if vec==15 → DONE. Otherwise vec+1 and hold_cnt←0.
  - DONE: done=1 for this cycle; pass←(final err_count==0); a..d←0 → IDLE.
- a..d are registered from vec. They are 0 whenever the block is not in DRIVE.
- A start that arrives while in DRIVE or DONE is ignored; it is not queued.
- exp_tt changes after start have no effect on the running sweep.
- err_count saturation is not needed; 5 bits covers the maximum of 16.
- The pass/err_count/fail_mask update made in the final sample cycle must be visible on done, so pass is computed from the updated count.
- hold_cnt width is max(1, $clog2(HOLD_CYCLES)). When HOLD_CYCLES=1, every DRIVE cycle is a sample cycle.

## Timing
- Reset values: a=b=c=d=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state=IDLE.
- start sampled high at cycle 0 → DRIVE from cycle 1, vector 0 on a..d in cycle 1.
- Vector k is driven in cycles 1+k·H … (k+1)·H, where H=HOLD_CYCLES. f is sampled in cycle (k+1)·H.
- done pulses in cycle 16·H+1; busy falls in the same cycle; results are stable from that cycle.
- The earliest next accepted start is cycle 16·H+2, i.e. in IDLE.
- Reset mid-sweep: on the cycle after reset is sampled, all outputs are at reset values and state=IDLE. A partial sweep produces no done.
- Reset has priority over start in the same cycle.

## Structure
- Shared package logicfunction_pkg holds:
  - state enum (IDLE, DRIVE, DONE);
  - NUM_VECTORS=16, VEC_W=4, ERR_W=5.
- One sub-module, sweep_hold_timer: parameterised hold counter producing a sample-strobe. It is cleared on the vector advance and on reset.
- Top module holds the FSM, vector register, expected-table latch and result registers.

## Test plan
- Reset: hold reset 3 cycles with start=1 → all outputs 0, busy stays 0, no done.
- Clean pass: H=4, exp_tt=16'hA5C3, bench drives f=exp_tt[{a,b,c,d}], start at cycle 0 → busy=1 in cycles 1..64; done at cycle 65 with pass=1, err_count=0, fail_mask=16'h0000.
- Partial fail: exp_tt=16'h8001, f tied 0 → err_count=2, fail_mask=16'h8001, pass=0.
- Total fail: f=~exp_tt[vec] → err_count=16, fail_mask=16'hFFFF, pass=0.
- Ignored start and changing exp_tt:
  - start re-pulsed at cycles 10 and 65 → done only at 65, no restart.
  - Change exp_tt at cycle 5 → result uses the value latched at cycle 0.
- Mid-sweep reset and H=1: reset at cycle 30 → cycle 31 idle with outputs 0. New start at 40 with H=1 build → done at cycle 57, vectors 0..15 on cycles 41..56.
